led_ctrl: RTL and testbench
===========================

# led_ctrl

Parametrised multi-channel LED controller for board bring-up and status indication. It drives CH LED outputs from one clock. Each channel can be set to off, on, blink at its own half-period, or stretched activity indication. A shared prescaler generates a millisecond-class tick, so all timing is set in ticks rather than clock cycles. An optional global PWM brightness stage sits in front of the outputs.

## Interface
Parameters:
- CLK_HZ, 100000000: frequency of clk in Hz.
- TICK_HZ, 1000: tick rate. DIV = CLK_HZ/TICK_HZ (integer division). DIV >= 2 is required.
- CH, 6: number of LED channels, 1..32.
- STRETCH_TICKS, 50: activity on-time and gap length in ticks, >= 1.

Ports:
- clk  in  1  the single clock for the whole block.
- rst  in  1  reset, synchronous and active-high.
- mode_i  in  2*CH  per-channel mode, channel n at bits [2n+1:2n]: 00 off, 01 on, 10 blink, 11 activity.
- half_period_i  in  16*CH  per-channel blink half-period in ticks, channel n at bits [16n+15:16n]. Value 0 is treated as 1.
- act_i  in  CH  per-channel activity event, level-sampled on every clk edge.
- bright_i  in  8  global brightness. Used only when LED_CTRL_PWM_EN is defined.
- tick_o  out  1  one-cycle tick strobe.
- led_o  out  CH  LED drive, active-high, registered.

## Operation
- Reset: all counters 0, tick_o 0, led_o 0, every blink phase 1, every activity FSM in IDLE with pending cleared. rst overrides all other inputs, including mid-operation.
- Prescaler: counter runs 0..DIV-1 and wraps. tick_o is 1 in exactly the cycle the counter equals DIV-1.
- Off and on modes: raw output is 0 or 1 respectively.
- Blink mode, per channel:
  - 16-bit tick counter cnt. On each tick: if cnt >= max(half_period,1)-1, toggle phase and clear cnt; else increment cnt.
  - Raw output = phase.
  - While the mode is not 10: cnt=0 and phase=1. Entering blink therefore lights the LED at once for a full half-period.
  - half_period_i changes take effect at the next compare. If cnt is already past the new value, the toggle happens at the next tick.
- Activity mode, per channel FSM:
  - IDLE: raw 0. act_i=1 moves to ON and clears cnt.
  - ON: raw 1. On each tick cnt increments. At a tick with cnt==STRETCH_TICKS-1, move to GAP and clear cnt. act_i is ignored in ON.
  - GAP: raw 0. act_i=1 sets pending. At a tick with cnt==STRETCH_TICKS-1: go to ON if pending (or act_i this cycle), else IDLE. pending is cleared either way.
  - While the mode is not 11: FSM forced to IDLE, pending cleared.
- Output: led_o[n] is registered from raw[n], gated by the PWM stage when that stage is enabled.

## Timing
- Latency: mode_i change to led_o is 1 cycle. act_i sampled at edge N gives ON at edge N, and led_o=1 after edge N+1.
- Blink: high and low phases are each exactly max(half_period,1)*DIV cycles in steady state.
- Activity ON length is between (STRETCH_TICKS-1)*DIV+1 and STRETCH_TICKS*DIV cycles, because it depends on prescaler alignment. GAP length follows the same rule.
- All channels share the prescaler, so channels in blink mode with equal half-periods stay phase-locked once entered on the same tick.

## Configuration
- LED_CTRL_PWM_EN defined:
  - An 8-bit free-running counter pwm runs from reset value 0 and increments every clk.
  - led_o[n] = raw[n] & (pwm < bright_i), registered.
  - bright_i=0 forces all LEDs off. bright_i=255 gives 255/256 duty.
- LED_CTRL_PWM_EN undefined: no PWM counter, bright_i is unused, and led_o = raw, registered.

## Test plan
All scenarios use CLK_HZ=1000, TICK_HZ=100 (DIV=10), CH=4, STRETCH_TICKS=3.
- Reset: rst=1 for 3 cycles with all modes 01 -> led_o=0 and tick_o=0 during reset. led_o=4'hF 1 cycle after release. First tick_o on the 10th cycle after release, then every 10 cycles.
- Blink: ch0 mode 10, half_period 3 -> led_o[0] on immediately, then alternates 30 cycles high / 30 low. half_period 0 -> alternates 10/10.
- Activity: single 1-cycle act_i[1] pulse -> led_o[1] high for 21..30 cycles, then low for the gap, then stays low. A second pulse during ON is ignored. A pulse during GAP relights ON directly at gap end.
- Mode switch: ch2 blink->off mid high phase -> led_o[2]=0 one cycle later. Back to blink -> led_o[2]=1 one cycle later, held for a full 30 cycles.
- Reset mid-activity: rst asserted during ON -> led_o=0 the next cycle. After release, the FSM is IDLE until a new act_i.
- PWM (macro defined): ch3 mode 01, bright_i=64 -> led_o[3] high exactly 64 of every 256 cycles. bright_i=0 -> 0 cycles high.

Source files
------------

// File: rtl/led_ctrl.sv
// rtl/led_ctrl.sv - multi-channel LED controller (off/on/blink/activity), optional PWM stage under LED_CTRL_PWM_EN
module led_ctrl #(
  parameter int CLK_HZ        = 100000000,
  parameter int TICK_HZ       = 1000,
  parameter int CH            = 6,
  parameter int STRETCH_TICKS = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2*CH-1:0]   mode_i,
  input  logic [16*CH-1:0]  half_period_i,
  input  logic [CH-1:0]     act_i,
  input  logic [7:0]        bright_i,
  output logic              tick_o,
  output logic [CH-1:0]     led_o
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (STRETCH_TICKS > 1) ? $clog2(STRETCH_TICKS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [AW-1:0] ACT_LAST   = AW'(STRETCH_TICKS - 1);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_ACT   = 2'b11;

  typedef enum logic [1:0] {
    ACT_IDLE = 2'd0,
    ACT_ON   = 2'd1,
    ACT_GAP  = 2'd2
  } act_state_t;

  logic [PW-1:0] presc_q;
  logic          tick;
  logic [CH-1:0] raw;
  logic [CH-1:0] gate;

  assign tick   = (presc_q == PRESC_LAST);
  assign tick_o = tick;

  // Shared prescaler: counts 0..DIV-1, tick fires on the last count
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  for (genvar n = 0; n < CH; n++) begin : g_ch
    logic [1:0]  mode;
    logic [15:0] hp;
    logic [15:0] hp_last;
    logic        act;
    logic [15:0] bcnt_q;
    logic        phase_q;
    act_state_t  state_q, state_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic        pend_q, pend_d;
    logic        act_raw;

    assign mode    = mode_i[2*n +: 2];
    assign hp      = half_period_i[16*n +: 16];
    // A half-period of 0 behaves like 1, so both compare against 0
    assign hp_last = (hp == 16'd0) ? 16'd0 : hp - 16'd1;
    assign act     = act_i[n];

    // Blink counter and phase; held at phase 1 outside blink so entry lights at once
    always_ff @(posedge clk) begin
      if (rst || mode != MODE_BLINK) begin
        bcnt_q  <= '0;
        phase_q <= 1'b1;
      end else if (tick) begin
        if (bcnt_q >= hp_last) begin
          phase_q <= ~phase_q;
          bcnt_q  <= '0;
        end else begin
          bcnt_q <= bcnt_q + 16'd1;
        end
      end
    end

    // Activity FSM state register; parked in IDLE unless the channel is in activity mode
    always_ff @(posedge clk) begin
      if (rst || mode != MODE_ACT) begin
        state_q <= ACT_IDLE;
        acnt_q  <= '0;
        pend_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        acnt_q  <= acnt_d;
        pend_q  <= pend_d;
      end
    end

    // Activity FSM next state: stretched ON, then a GAP that may chain into another ON
    always_comb begin
      state_d = state_q;
      acnt_d  = acnt_q;
      pend_d  = pend_q;
      act_raw = 1'b0;
      case (state_q)
        ACT_IDLE: begin
          if (act) begin
            state_d = ACT_ON;
            acnt_d  = '0;
          end
        end
        ACT_ON: begin
          act_raw = 1'b1;
          if (tick) begin
            if (acnt_q == ACT_LAST) begin
              state_d = ACT_GAP;
              acnt_d  = '0;
            end else begin
              acnt_d = acnt_q + 1'b1;
            end
          end
        end
        ACT_GAP: begin
          if (act) begin
            pend_d = 1'b1;
          end
          if (tick) begin
            if (acnt_q == ACT_LAST) begin
              state_d = (pend_q || act) ? ACT_ON : ACT_IDLE;
              pend_d  = 1'b0;
              acnt_d  = '0;
            end else begin
              acnt_d = acnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ACT_IDLE;
          acnt_d  = '0;
          pend_d  = 1'b0;
        end
      endcase
    end

    assign raw[n] = (mode == MODE_OFF)   ? 1'b0 :
                    (mode == MODE_ON)    ? 1'b1 :
                    (mode == MODE_BLINK) ? phase_q :
                                           act_raw;
  end

`ifdef LED_CTRL_PWM_EN
  logic [7:0] pwm_q;

  // Free-running PWM ramp compared against the global brightness
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + 8'd1;
    end
  end

  assign gate = {CH{pwm_q < bright_i}};
`else
  logic unused_bright;
  assign unused_bright = ^bright_i;
  assign gate = '1;
`endif

  // Registered LED drive
  always_ff @(posedge clk) begin
    if (rst) begin
      led_o <= '0;
    end else begin
      led_o <= raw & gate;
    end
  end

endmodule

// File: tb/tb_led_ctrl.sv
// tb/tb_led_ctrl.sv - self-checking bench for led_ctrl against a behavioural model
module tb_led_ctrl;
  localparam int CLK_HZ = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CH = 4;
  localparam int ST = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  mode_i;
  logic [63:0] half_period_i;
  logic [3:0]  act_i;
  logic [7:0]  bright_i;
  logic        tick_o;
  logic [3:0]  led_o;

  led_ctrl #(
    .CLK_HZ(CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .CH(CH),
    .STRETCH_TICKS(ST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode_i(mode_i),
    .half_period_i(half_period_i),
    .act_i(act_i),
    .bright_i(bright_i),
    .tick_o(tick_o),
    .led_o(led_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: ticks, blink timers and activity stretchers in plain integers
  int m_presc, m_pwm;
  int m_cnt[CH], m_phase[CH], m_st[CH], m_acnt[CH], m_pend[CH], m_led[CH];

  task automatic model_edge();
    int mode, hp, raw, tick_now, gate, a;
    if (rst) begin
      m_presc = 0;
      m_pwm = 0;
      for (int c = 0; c < CH; c++) begin
        m_cnt[c] = 0; m_phase[c] = 1; m_st[c] = 0; m_acnt[c] = 0; m_pend[c] = 0; m_led[c] = 0;
      end
      return;
    end
    tick_now = (m_presc == DIV - 1) ? 1 : 0;
`ifdef LED_CTRL_PWM_EN
    gate = (m_pwm < int'(bright_i)) ? 1 : 0;
`else
    gate = 1;
`endif
    for (int c = 0; c < CH; c++) begin
      mode = int'(mode_i[2*c +: 2]);
      hp = int'(half_period_i[16*c +: 16]);
      if (hp < 1) hp = 1;
      a = int'(act_i[c]);
      case (mode)
        0: raw = 0;
        1: raw = 1;
        2: raw = m_phase[c];
        default: raw = (m_st[c] == 1) ? 1 : 0;
      endcase
      m_led[c] = raw & gate;
      if (mode != 2) begin
        m_cnt[c] = 0; m_phase[c] = 1;
      end else if (tick_now != 0) begin
        if (m_cnt[c] >= hp - 1) begin
          m_phase[c] = 1 - m_phase[c]; m_cnt[c] = 0;
        end else begin
          m_cnt[c]++;
        end
      end
      if (mode != 3) begin
        m_st[c] = 0; m_pend[c] = 0; m_acnt[c] = 0;
      end else if (m_st[c] == 0) begin
        if (a != 0) begin m_st[c] = 1; m_acnt[c] = 0; end
      end else if (m_st[c] == 1) begin
        if (tick_now != 0) begin
          if (m_acnt[c] == ST - 1) begin m_st[c] = 2; m_acnt[c] = 0; end
          else m_acnt[c]++;
        end
      end else begin
        if (tick_now != 0 && m_acnt[c] == ST - 1) begin
          m_st[c] = (m_pend[c] != 0 || a != 0) ? 1 : 0;
          m_pend[c] = 0; m_acnt[c] = 0;
        end else begin
          if (a != 0) m_pend[c] = 1;
          if (tick_now != 0) m_acnt[c]++;
        end
      end
    end
    m_presc = (tick_now != 0) ? 0 : m_presc + 1;
    m_pwm = (m_pwm + 1) % 256;
  endtask

  function automatic logic [3:0] exp_led();
    logic [3:0] r;
    for (int c = 0; c < CH; c++) r[c] = (m_led[c] != 0);
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("led_model", 32'(led_o), 32'(exp_led()));
    check("tick_model", 32'(tick_o), (m_presc == DIV - 1) ? 32'd1 : 32'd0);
  endtask

  task automatic set_mode(input int c, input logic [1:0] m);
    mode_i[2*c +: 2] = m;
  endtask

  task automatic set_hp(input int c, input logic [15:0] h);
    half_period_i[16*c +: 16] = h;
  endtask

  // Length of the current run of led_o[idx], including the present sample
  task automatic run_len(input int idx, input int max, output int len);
    logic v;
    v = led_o[idx];
    len = 0;
    while (led_o[idx] === v && len < max) begin
      len++;
      cycle();
    end
  endtask

  task automatic wait_change(input int idx, input int max, input string tag);
    logic v;
    int n;
    v = led_o[idx];
    n = 0;
    while (led_o[idx] === v && n < max) begin
      cycle();
      n++;
    end
    check(tag, (n < max) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Leave the bench just after a tick edge, so a change made now is seen nine edges before the next tick
  task automatic align_tick();
    int n;
    n = 0;
    while (tick_o !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    check("align_timeout", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    cycle();
  endtask

  task automatic pulse_act(input int c);
    act_i[c] = 1'b1;
    cycle();
    act_i[c] = 1'b0;
  endtask

  initial begin
    int k, len, hi;
    rst = 1'b1;
    mode_i = 8'b01010101;
    half_period_i = '0;
    act_i = '0;
    bright_i = 8'hFF;
    @(negedge clk);

    // Reset and prescaler start-up
    repeat (3) begin
      cycle();
      check("rst_led", 32'(led_o), 32'd0);
      check("rst_tick", 32'(tick_o), 32'd0);
    end
    rst = 1'b0;
    cycle();
    check("release_led", 32'(led_o), 32'hF);
    k = 2;
    while (tick_o !== 1'b1 && k < 50) begin
      cycle();
      k++;
    end
    check("first_tick_cycle", k, 10);
    k = 0;
    do begin
      cycle();
      k++;
    end while (tick_o !== 1'b1 && k < 50);
    check("tick_period", k, 10);

    // Blink on ch0 with half-period 3, then 0
    mode_i = 8'b00000000;
    set_hp(0, 16'd3);
    align_tick();
    set_mode(0, 2'b10);
    cycle();
    check("blink_enter", 32'(led_o[0]), 32'd1);
    run_len(0, 100, len);
    check("blink_first_high", len, 30);
    run_len(0, 100, len);
    check("blink_low", len, 30);
    run_len(0, 100, len);
    check("blink_high", len, 30);
    set_hp(0, 16'd0);
    wait_change(0, 40, "blink_hp0_change");
    run_len(0, 100, len);
    check("blink_hp0_a", len, 10);
    run_len(0, 100, len);
    check("blink_hp0_b", len, 10);

    // Mode switch on ch2
    set_mode(0, 2'b00);
    set_hp(2, 16'd3);
    align_tick();
    set_mode(2, 2'b10);
    repeat (10) cycle();
    check("ch2_high_before_off", 32'(led_o[2]), 32'd1);
    set_mode(2, 2'b00);
    cycle();
    check("ch2_off_latency", 32'(led_o[2]), 32'd0);
    repeat (7) cycle();
    align_tick();
    set_mode(2, 2'b10);
    cycle();
    check("ch2_reenter", 32'(led_o[2]), 32'd1);
    run_len(2, 100, len);
    check("ch2_reenter_high", len, 30);
    set_mode(2, 2'b00);

    // Activity on ch1: single pulse
    set_mode(1, 2'b11);
    repeat (3) cycle();
    pulse_act(1);
    check("act_latency_n", 32'(led_o[1]), 32'd0);
    cycle();
    check("act_latency_n1", 32'(led_o[1]), 32'd1);
    run_len(1, 40, len);
    check("act_on_range", (len >= 21 && len <= 30) ? 32'd1 : 32'd0, 32'd1);
    run_len(1, 40, len);
    check("act_idle_after", len, 40);

    // Second pulse during ON is ignored
    pulse_act(1);
    cycle();
    repeat (5) cycle();
    pulse_act(1);
    run_len(1, 40, len);
    run_len(1, 40, len);
    check("act_on_pulse_ignored", len, 40);

    // Pulse during GAP chains straight into a new ON
    pulse_act(1);
    cycle();
    run_len(1, 40, len);
    repeat (5) cycle();
    pulse_act(1);
    run_len(1, 40, len);
    check("act_relight", 32'(led_o[1]), 32'd1);
    run_len(1, 40, len);
    check("act_relight_len", len, 30);
    run_len(1, 40, len);
    check("act_idle_final", len, 40);

    // Reset during ON
    pulse_act(1);
    repeat (5) cycle();
    check("act_on_before_rst", 32'(led_o[1]), 32'd1);
    rst = 1'b1;
    cycle();
    check("rst_mid_led", 32'(led_o), 32'd0);
    rst = 1'b0;
    run_len(1, 40, len);
    check("rst_mid_idle", len, 40);

    // Brightness stage on ch3
    mode_i = 8'b01000000;
    bright_i = 8'd64;
    repeat (3) cycle();
    hi = 0;
    repeat (256) begin
      cycle();
      hi += int'(led_o[3]);
    end
`ifdef LED_CTRL_PWM_EN
    check("pwm_64", hi, 64);
`else
    check("pwm_64", hi, 256);
`endif
    bright_i = 8'd0;
    repeat (3) cycle();
    hi = 0;
    repeat (256) begin
      cycle();
      hi += int'(led_o[3]);
    end
`ifdef LED_CTRL_PWM_EN
    check("pwm_0", hi, 0);
`else
    check("pwm_0", hi, 256);
`endif

    // Randomized traffic against the model
    bright_i = 8'hFF;
    repeat (2500) begin
      if ($urandom_range(39) == 0) set_mode(int'($urandom_range(CH - 1)), 2'($urandom_range(3)));
      if ($urandom_range(59) == 0) set_hp(int'($urandom_range(CH - 1)), 16'($urandom_range(4)));
      if ($urandom_range(99) == 0) bright_i = 8'($urandom_range(255));
      for (int c = 0; c < CH; c++) act_i[c] = ($urandom_range(15) == 0);
      rst = ($urandom_range(299) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
